// File: rtl/mips_enc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_enc_pkg
//  Description : Shared definitions for the MIPS instruction encoder:
//                request op enumeration, primary opcode / function codes,
//                instruction bit-field positions, FIFO control states and
//                small helpers that assemble R/I/J format words.
//  Revision    : 1.0  initial release
// ============================================================================
package mips_enc_pkg;

    // Request op select presented on req_op
    typedef enum logic [3:0] {
        OP_NOP   = 4'd0,
        OP_ADD   = 4'd1,
        OP_SUB   = 4'd2,
        OP_SLT   = 4'd3,
        OP_NOR   = 4'd4,
        OP_ADDI  = 4'd5,
        OP_ANDI  = 4'd6,
        OP_LUI   = 4'd7,
        OP_LW    = 4'd8,
        OP_SW    = 4'd9,
        OP_BEQ   = 4'd10,
        OP_BNE   = 4'd11,
        OP_J     = 4'd12,
        OP_JR    = 4'd13,
        OP_ILL14 = 4'd14,
        OP_ILL15 = 4'd15
    } req_op_e;

    // Primary opcodes (bits 31:26)
    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_J     = 6'h02;
    localparam logic [5:0] OPC_BEQ   = 6'h04;
    localparam logic [5:0] OPC_BNE   = 6'h05;
    localparam logic [5:0] OPC_ADDI  = 6'h08;
    localparam logic [5:0] OPC_ANDI  = 6'h0C;
    localparam logic [5:0] OPC_LUI   = 6'h0F;
    localparam logic [5:0] OPC_LW    = 6'h23;
    localparam logic [5:0] OPC_SW    = 6'h2B;

    // R-type function codes (bits 5:0)
    localparam logic [5:0] FUNC_JR   = 6'h08;
    localparam logic [5:0] FUNC_ADD  = 6'h20;
    localparam logic [5:0] FUNC_SUB  = 6'h22;
    localparam logic [5:0] FUNC_NOR  = 6'h27;
    localparam logic [5:0] FUNC_SLT  = 6'h2A;

    // Instruction bit-field positions
    localparam int OP_MSB    = 31;
    localparam int OP_LSB    = 26;
    localparam int RS_MSB    = 25;
    localparam int RS_LSB    = 21;
    localparam int RT_MSB    = 20;
    localparam int RT_LSB    = 16;
    localparam int RD_MSB    = 15;
    localparam int RD_LSB    = 11;
    localparam int SHAMT_MSB = 10;
    localparam int SHAMT_LSB = 6;
    localparam int FUNC_MSB  = 5;
    localparam int FUNC_LSB  = 0;
    localparam int IMM_MSB   = 15;
    localparam int IMM_LSB   = 0;
    localparam int TGT_MSB   = 25;
    localparam int TGT_LSB   = 0;

    // Output FIFO occupancy doubles as the control state
    typedef enum logic [1:0] {
        FIFO_EMPTY = 2'd0,
        FIFO_ONE   = 2'd1,
        FIFO_FULL  = 2'd2
    } fifo_state_e;

    // R-format word, shamt always zero
    function automatic logic [31:0] enc_r(input logic [4:0] rs,
                                          input logic [4:0] rt,
                                          input logic [4:0] rd,
                                          input logic [5:0] func);
        logic [31:0] w;
        w                     = '0;
        w[OP_MSB:OP_LSB]      = OPC_RTYPE;
        w[RS_MSB:RS_LSB]      = rs;
        w[RT_MSB:RT_LSB]      = rt;
        w[RD_MSB:RD_LSB]      = rd;
        w[SHAMT_MSB:SHAMT_LSB] = 5'd0;
        w[FUNC_MSB:FUNC_LSB]  = func;
        return w;
    endfunction

    // I-format word, immediate passed through verbatim
    function automatic logic [31:0] enc_i(input logic [5:0]  opc,
                                          input logic [4:0]  rs,
                                          input logic [4:0]  rt,
                                          input logic [15:0] imm);
        logic [31:0] w;
        w                 = '0;
        w[OP_MSB:OP_LSB]  = opc;
        w[RS_MSB:RS_LSB]  = rs;
        w[RT_MSB:RT_LSB]  = rt;
        w[IMM_MSB:IMM_LSB] = imm;
        return w;
    endfunction

    // J-format word
    function automatic logic [31:0] enc_j(input logic [5:0]  opc,
                                          input logic [25:0] tgt);
        logic [31:0] w;
        w                  = '0;
        w[OP_MSB:OP_LSB]   = opc;
        w[TGT_MSB:TGT_LSB] = tgt;
        return w;
    endfunction

endpackage : mips_enc_pkg
`default_nettype wire

// File: rtl/mips_enc_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : mips_enc_fifo
//  Description : Two-entry FIFO whose occupancy is the control state
//                (EMPTY / ONE / FULL). Synchronous clear wins over push
//                and pop. Head reads as zero while empty.
//  Ports       : clk, rst_n      clock, async active-low reset
//                clr_i           synchronous flush
//                push_i, data_i  write request and data
//                pop_i           remove head
//                data_o          head entry (zero when empty)
//                count_o         occupancy 0..2
//  Revision    : 1.0  initial release
// ============================================================================
module mips_enc_fifo
    import mips_enc_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o,
    output logic [1:0]        count_o
);

    fifo_state_e       state_q, state_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] mem_q [2];

    logic w_push;
    logic w_pop;

    // Overflow / underflow requests are ignored rather than corrupting state
    assign w_push = push_i && (state_q != FIFO_FULL);
    assign w_pop  = pop_i  && (state_q != FIFO_EMPTY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= FIFO_EMPTY;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clr_i) begin
            state_d  = FIFO_EMPTY;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
        end else begin
            if (w_push) wr_ptr_d = ~wr_ptr_q;
            if (w_pop)  rd_ptr_d = ~rd_ptr_q;
            case (state_q)
                FIFO_EMPTY: if (w_push) state_d = FIFO_ONE;
                FIFO_ONE: begin
                    if (w_push && !w_pop)      state_d = FIFO_FULL;
                    else if (w_pop && !w_push) state_d = FIFO_EMPTY;
                end
                FIFO_FULL:  if (w_pop) state_d = FIFO_ONE;
                default:    state_d = FIFO_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) mem_q[i] <= '0;
        end else if (w_push && !clr_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign data_o  = (state_q == FIFO_EMPTY) ? '0 : mem_q[rd_ptr_q];
    assign count_o = state_q;

endmodule : mips_enc_fifo
`default_nettype wire

// File: rtl/mips_instr_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : mips_instr_encoder
//  Description : Encodes a request (op + register/immediate/target fields)
//                into a 32-bit MIPS instruction word, buffers it in a
//                2-entry FIFO and emits it with an instruction-memory word
//                address that advances on every output handshake.
//  Config      : MIPS_ENC_JR_EN - when defined, op 13 encodes JR; when
//                undefined, op 13 is treated as illegal.
//  Ports       : clk, rst_n                 clock, async active-low reset
//                clr                        synchronous flush
//                req_valid/req_ready        request handshake
//                req_op, req_rs, req_rt,
//                req_rd, req_imm, req_target request fields
//                out_valid/out_ready        output handshake
//                out_word, out_addr         encoded word and its address
//                err_illegal, wrapped       sticky status flags
//  Revision    : 1.0  initial release
// ============================================================================
module mips_instr_encoder
    import mips_enc_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_op,
    input  logic [4:0]        req_rs,
    input  logic [4:0]        req_rt,
    input  logic [4:0]        req_rd,
    input  logic [15:0]       req_imm,
    input  logic [25:0]       req_target,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_word,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err_illegal,
    output logic              wrapped
);

    logic              rdy_en_q;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              err_q, err_d;
    logic              wrap_q, wrap_d;

    logic [31:0] w_word;
    logic        w_illegal;
    logic        w_push;
    logic        w_pop;
    logic [1:0]  w_count;

    // ---------------- instruction encoder ----------------
    always_comb begin
        w_word    = '0;
        w_illegal = 1'b0;
        case (req_op)
            OP_NOP:  w_word = '0;
            OP_ADD:  w_word = enc_r(req_rs, req_rt, req_rd, FUNC_ADD);
            OP_SUB:  w_word = enc_r(req_rs, req_rt, req_rd, FUNC_SUB);
            OP_SLT:  w_word = enc_r(req_rs, req_rt, req_rd, FUNC_SLT);
            OP_NOR:  w_word = enc_r(req_rs, req_rt, req_rd, FUNC_NOR);
            OP_ADDI: w_word = enc_i(OPC_ADDI, req_rs, req_rt, req_imm);
            OP_ANDI: w_word = enc_i(OPC_ANDI, req_rs, req_rt, req_imm);
            OP_LUI:  w_word = enc_i(OPC_LUI,  5'd0,   req_rt, req_imm);
            OP_LW:   w_word = enc_i(OPC_LW,   req_rs, req_rt, req_imm);
            OP_SW:   w_word = enc_i(OPC_SW,   req_rs, req_rt, req_imm);
            OP_BEQ:  w_word = enc_i(OPC_BEQ,  req_rs, req_rt, req_imm);
            OP_BNE:  w_word = enc_i(OPC_BNE,  req_rs, req_rt, req_imm);
            OP_J:    w_word = enc_j(OPC_J, req_target);
`ifdef MIPS_ENC_JR_EN
            OP_JR:   w_word = enc_r(req_rs, 5'd0, 5'd0, FUNC_JR);
`else
            OP_JR:   w_illegal = 1'b1;
`endif
            default: w_illegal = 1'b1;
        endcase
    end

    // ---------------- handshakes ----------------
    // rdy_en_q holds req_ready low until the first edge after reset release.
    assign req_ready = rdy_en_q && (w_count != 2'd2) && !clr;
    assign out_valid = (w_count != 2'd0);
    assign w_push    = req_valid && req_ready;
    assign w_pop     = out_valid && out_ready;

    mips_enc_fifo #(
        .DATA_W (32)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (clr),
        .push_i  (w_push),
        .pop_i   (w_pop),
        .data_i  (w_word),
        .data_o  (out_word),
        .count_o (w_count)
    );

    // ---------------- address counter and sticky flags ----------------
    always_comb begin
        addr_d = addr_q;
        err_d  = err_q;
        wrap_d = wrap_q;
        if (clr) begin
            addr_d = '0;
            err_d  = 1'b0;
            wrap_d = 1'b0;
        end else begin
            if (w_pop) begin
                addr_d = addr_q + ADDR_W'(1);
                if (&addr_q) wrap_d = 1'b1;
            end
            if (w_push && w_illegal) err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_en_q <= 1'b0;
            addr_q   <= '0;
            err_q    <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            rdy_en_q <= 1'b1;
            addr_q   <= addr_d;
            err_q    <= err_d;
            wrap_q   <= wrap_d;
        end
    end

    assign out_addr    = addr_q;
    assign err_illegal = err_q;
    assign wrapped     = wrap_q;

endmodule : mips_instr_encoder
`default_nettype wire

// File: tb/tb_mips_instr_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mips_instr_encoder
//  Description : Scoreboard bench for mips_instr_encoder. Accepted requests
//                push {expected word, expected address}; an independent
//                monitor pops and compares on every output handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mips_instr_encoder;

    localparam int ADDR_W = 8;

    typedef struct packed {
        logic [31:0]       word;
        logic [ADDR_W-1:0] addr;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              clr;
    logic              req_valid;
    logic              req_ready;
    logic [3:0]        req_op;
    logic [4:0]        req_rs, req_rt, req_rd;
    logic [15:0]       req_imm;
    logic [25:0]       req_target;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_word;
    logic [ADDR_W-1:0] out_addr;
    logic              err_illegal;
    logic              wrapped;

    exp_t              sb_q[$];
    logic [ADDR_W-1:0] next_addr;
    int                n_cmp = 0;
    int                n_bad = 0;

    always #5 clk = ~clk;

    mips_instr_encoder #(.ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (clr),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_rs      (req_rs),
        .req_rt      (req_rt),
        .req_rd      (req_rd),
        .req_imm     (req_imm),
        .req_target  (req_target),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_word    (out_word),
        .out_addr    (out_addr),
        .err_illegal (err_illegal),
        .wrapped     (wrapped)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare every word that actually leaves the DUT
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && !clr && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL mon_unexpected: got word 0x%08h with nothing expected", out_word);
            end else begin
                e = sb_q.pop_front();
                chk("mon_word", out_word, e.word);
                chk("mon_addr", 32'(out_addr), 32'(e.addr));
            end
        end
    end

    // Issue one request; waits (bounded) for acceptance. Entered/left at posedge+1.
    task automatic send(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt,
                        input logic [31:0] exp_word);
        bit acc = 0;
        req_op = op; req_rs = rs; req_rt = rt; req_rd = rd;
        req_imm = imm; req_target = tgt; req_valid = 1'b1;
        for (int k = 0; k < 64 && !acc; k++) begin
            @(negedge clk);
            if (req_ready) begin
                sb_q.push_back('{word: exp_word, addr: next_addr});
                next_addr = next_addr + 1'b1;
                acc = 1;
            end
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        if (!acc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: got no acceptance expected acceptance for op %0d", op);
        end
    endtask

    task automatic do_clr();
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        sb_q.delete();
        next_addr = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; clr = 1'b0; req_valid = 1'b0; out_ready = 1'b0;
        req_op = '0; req_rs = '0; req_rt = '0; req_rd = '0; req_imm = '0; req_target = '0;
        next_addr = '0;

        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        #2;
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_word", out_word, 0);
        chk("rst_addr", 32'(out_addr), 0);
        chk("rst_err", 32'(err_illegal), 0);
        chk("rst_wrap", 32'(wrapped), 0);
        chk("rst_ready", 32'(req_ready), 0);
        rst_n = 1'b1;
        #1;
        chk("ready_before_edge", 32'(req_ready), 0);
        @(posedge clk); #1;
        chk("ready_after_edge", 32'(req_ready), 1);

        // ---------------- basic encode, latency ----------------
        out_ready = 1'b1;
        chk("pre_valid", 32'(out_valid), 0);
        send(4'd1, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 32'h00221820);   // ADD
        chk("lat_valid", 32'(out_valid), 1);
        chk("lat_word", out_word, 32'h00221820);
        idle(2);

        send(4'd5,  5'd0,  5'd8, 5'd0,  16'hFFFF, 26'h0,      32'h2008FFFF); // ADDI
        send(4'd12, 5'd0,  5'd0, 5'd0,  16'h0,    26'h0000010, 32'h08000010); // J
        send(4'd7,  5'd5,  5'd1, 5'd0,  16'h1234, 26'h0,      32'h3C011234); // LUI
        send(4'd2,  5'd4,  5'd5, 5'd6,  16'h0,    26'h0,      32'h00853022); // SUB
        send(4'd3,  5'd7,  5'd8, 5'd9,  16'h0,    26'h0,      32'h00E8482A); // SLT
        send(4'd4,  5'd1,  5'd1, 5'd1,  16'h0,    26'h0,      32'h00210827); // NOR
        send(4'd6,  5'd2,  5'd3, 5'd31, 16'h00FF, 26'h0,      32'h304300FF); // ANDI
        send(4'd8,  5'd29, 5'd4, 5'd0,  16'h0010, 26'h0,      32'h8FA40010); // LW
        send(4'd9,  5'd29, 5'd5, 5'd0,  16'hFFFC, 26'h0,      32'hAFA5FFFC); // SW
        send(4'd10, 5'd1,  5'd2, 5'd0,  16'hFFFE, 26'h0,      32'h1022FFFE); // BEQ
        send(4'd11, 5'd3,  5'd0, 5'd0,  16'h0003, 26'h0,      32'h14600003); // BNE
        send(4'd0,  5'd9,  5'd9, 5'd9,  16'hAAAA, 26'h3FFFFFF, 32'h00000000); // NOP
        idle(2);
        chk("legal_err", 32'(err_illegal), 0);

        // ---------------- JR and illegal op ----------------
`ifdef MIPS_ENC_JR_EN
        send(4'd13, 5'd31, 5'd7, 5'd7, 16'h0, 26'h0, 32'h03E00008);
        chk("jr_err", 32'(err_illegal), 0);
`else
        send(4'd13, 5'd31, 5'd7, 5'd7, 16'h0, 26'h0, 32'h00000000);
        chk("jr_err", 32'(err_illegal), 1);
`endif
        send(4'd15, 5'd31, 5'd7, 5'd7, 16'h1234, 26'h1, 32'h00000000);
        chk("ill_err", 32'(err_illegal), 1);
        idle(2);
        do_clr();
        chk("clr_err", 32'(err_illegal), 0);
        chk("clr_addr0", 32'(out_addr), 0);

        // ---------------- backpressure ----------------
        out_ready = 1'b0;
        send(4'd1, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 32'h00221820);
        send(4'd2, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0, 32'h00853022);
        req_op = 4'd7; req_rs = 5'd5; req_rt = 5'd1; req_imm = 16'h1234; req_valid = 1'b1;
        @(negedge clk);
        chk("bp_ready0", 32'(req_ready), 0);
        chk("bp_head", out_word, 32'h00221820);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_ready1", 32'(req_ready), 0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(4'd7, 5'd5, 5'd1, 5'd0, 16'h1234, 26'h0, 32'h3C011234);
        idle(3);
        chk("bp_drained", 32'(out_valid), 0);

        // ---------------- address wrap ----------------
        do_clr();
        for (int i = 0; i < 255; i++)
            send(4'd5, 5'd0, 5'd0, 5'd0, 16'(i), 26'h0, 32'h20000000 | 32'(i));
        idle(2);
        chk("pre_wrap_addr", 32'(out_addr), 255);
        chk("pre_wrap_flag", 32'(wrapped), 0);
        send(4'd5, 5'd0, 5'd0, 5'd0, 16'd255, 26'h0, 32'h200000FF);
        idle(2);
        chk("wrap_addr", 32'(out_addr), 0);
        chk("wrap_flag", 32'(wrapped), 1);
        send(4'd5, 5'd0, 5'd0, 5'd0, 16'd256, 26'h0, 32'h20000100);
        idle(2);

        // ---------------- clr with queued words and a pending request ----------------
        out_ready = 1'b0;
        send(4'd1, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 32'h00221820);
        send(4'd2, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0, 32'h00853022);
        req_op = 4'd12; req_target = 26'h55; req_valid = 1'b1;
        clr = 1'b1;
        @(negedge clk);
        chk("clr_ready", 32'(req_ready), 0);
        @(posedge clk); #1;
        clr = 1'b0; req_valid = 1'b0;
        sb_q.delete();
        next_addr = '0;
        chk("clr_valid", 32'(out_valid), 0);
        chk("clr_addr", 32'(out_addr), 0);
        chk("clr_wrap", 32'(wrapped), 0);
        idle(1);
        chk("clr_noaccept", 32'(out_valid), 0);

        // ---------------- reset mid-stream ----------------
        send(4'd15, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 32'h00000000);
        send(4'd1,  5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 32'h00221820);
        chk("mid_err_set", 32'(err_illegal), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_valid", 32'(out_valid), 0);
        chk("mid_word", out_word, 0);
        chk("mid_addr", 32'(out_addr), 0);
        chk("mid_err", 32'(err_illegal), 0);
        chk("mid_wrap", 32'(wrapped), 0);
        chk("mid_ready", 32'(req_ready), 0);
        sb_q.delete();
        next_addr = '0;
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("mid_ready_rise", 32'(req_ready), 1);
        chk("mid_empty", 32'(out_valid), 0);

        // ---------------- final word and drain ----------------
        out_ready = 1'b1;
        send(4'd12, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0000010, 32'h08000010);
        for (int k = 0; k < 20 && sb_q.size() != 0; k++) idle(1);
        chk("drain", 32'(sb_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_mips_instr_encoder
`default_nettype wire
